// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit controller: frame geometry,
// state encoding and frame bit positions.
package uart_pkg;

  localparam int FRAME_BITS = 11;
  localparam int DATA_BITS  = 8;

  localparam int START_IDX = 0;
  localparam int DATA_LSB  = 1;
  localparam int DATA_MSB  = 8;
  localparam int PAR_IDX   = 9;
  localparam int STOP_IDX  = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2
  } state_t;

endpackage

// File: rtl/uart_tx_ctrl_baud_tick.sv
// Baud-rate divider: 16-bit counter that wraps at BAUD_DIV-1 and emits a
// one-cycle tick on the terminal count while not cleared.
module baud_tick #(
  parameter int BAUD_DIV = 5208
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam logic [15:0] TERM = 16'(BAUD_DIV - 1);

  logic [15:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= 16'd0;
    end else if (clr || (cnt == TERM)) begin
      cnt <= 16'd0;
    end else begin
      cnt <= cnt + 16'd1;
    end
  end

  assign tick = !clr && (cnt == TERM);

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: builds the parallel frame and sequences load/shift/done
// for a downstream shift register. Define UART_TX_PARITY_EN for a parity bit in frame[9].
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int BAUD_DIV   = 5208,
  parameter int FRAME_BITS = uart_pkg::FRAME_BITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            tx_data,
  input  logic                  tx_start,
  input  logic                  parity_odd,
  output logic [FRAME_BITS-1:0] frame,
  output logic                  load,
  output logic                  shift,
  output logic                  tx_busy,
  output logic                  tx_done
);

  localparam logic [3:0] LAST_BIT = 4'(FRAME_BITS - 1);

  state_t                state, state_nxt;
  logic [3:0]            bit_cnt;
  logic [FRAME_BITS-1:0] frame_q;
  logic [FRAME_BITS-1:0] frame_nxt;
  logic                  par_bit;
  logic                  accept;
  logic                  tick;

  baud_tick #(.BAUD_DIV(BAUD_DIV)) u_baud (
    .clk  (clk),
    .rst  (rst),
    .clr  (state != SEND),
    .tick (tick)
  );

`ifdef UART_TX_PARITY_EN
  assign par_bit = (^tx_data) ^ parity_odd;
`else
  logic unused_parity_odd;
  assign unused_parity_odd = parity_odd;
  assign par_bit = 1'b1;
`endif

  always_comb begin
    frame_nxt                    = '1;
    frame_nxt[START_IDX]         = 1'b0;
    frame_nxt[DATA_MSB:DATA_LSB] = tx_data;
    frame_nxt[PAR_IDX]           = par_bit;
    frame_nxt[STOP_IDX]          = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // A tx_start seen on the tx_done cycle is accepted so back-to-back frames
  // load in the very next cycle; any other tx_start during SEND is dropped.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    shift     = 1'b0;
    tx_done   = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (tx_start) begin
          accept    = 1'b1;
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        load      = 1'b1;
        state_nxt = SEND;
      end
      SEND: begin
        if (tick) begin
          if (bit_cnt == LAST_BIT) begin
            tx_done = 1'b1;
            if (tx_start) begin
              accept    = 1'b1;
              state_nxt = LOAD;
            end else begin
              state_nxt = IDLE;
            end
          end else begin
            shift = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt <= 4'd0;
    end else if (state != SEND) begin
      bit_cnt <= 4'd0;
    end else if (tick && (bit_cnt != LAST_BIT)) begin
      bit_cnt <= bit_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_q <= '1;
    end else if (accept) begin
      frame_q <= frame_nxt;
    end
  end

  assign frame   = frame_q;
  assign tx_busy = (state != IDLE);

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Scoreboard bench for uart_tx_ctrl with BAUD_DIV=4: stimulus pushes expected
// load/shift/done events, a negedge monitor pops and compares them.
module tb_uart_tx_ctrl;

  localparam int BD = 4;
  localparam int W  = 45;  // {kind[1:0], cycle[31:0], frame[10:0]}

  localparam logic [1:0] K_LOAD  = 2'd1;
  localparam logic [1:0] K_SHIFT = 2'd2;
  localparam logic [1:0] K_DONE  = 2'd3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  tx_data = 8'h00;
  logic        tx_start = 1'b0;
  logic        parity_odd = 1'b0;
  logic [10:0] frame;
  logic        load, shift, tx_busy, tx_done;

  logic [W-1:0] exp_q[$];
  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  uart_tx_ctrl #(.BAUD_DIV(BD)) dut (
    .clk        (clk),
    .rst        (rst),
    .tx_data    (tx_data),
    .tx_start   (tx_start),
    .parity_odd (parity_odd),
    .frame      (frame),
    .load       (load),
    .shift      (shift),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL timeout at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  function automatic logic [10:0] exp_frame(input logic [7:0] d, input logic odd);
    logic p;
`ifdef UART_TX_PARITY_EN
    p = (^d) ^ odd;
`else
    p = 1'b1;
`endif
    return {1'b1, p, d, 1'b0};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic push_frame(input int l, input logic [10:0] f);
    exp_q.push_back({K_LOAD, 32'(l), f});
    for (int k = 1; k <= 10; k++) exp_q.push_back({K_SHIFT, 32'(l + k * BD), f});
    exp_q.push_back({K_DONE, 32'(l + 11 * BD), f});
  endtask

  // driver: called at a negedge; returns the expected load cycle
  task automatic send_frame(input logic [7:0] d, input logic odd, output int l);
    tx_data    = d;
    parity_odd = odd;
    tx_start   = 1'b1;
    l = cyc + 1;
    push_frame(l, exp_frame(d, odd));
    @(negedge clk);
    tx_start = 1'b0;
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (!rst && (load || shift || tx_done)) begin
      logic [1:0]   kind;
      logic [W-1:0] e;
      kind = load ? K_LOAD : (shift ? K_SHIFT : K_DONE);
      check("pulse_exclusive", 64'($countones({load, shift, tx_done})), 64'd1);
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_event at cycle %0d: kind=%0d frame=%0h", cyc, kind, frame);
      end else begin
        e = exp_q.pop_front();
        check("event", 64'({kind, 32'(cyc), frame}), 64'(e));
      end
    end
  end

  initial begin
    int l, l0, l1, l2;
    logic [10:0] hand_41_even, hand_41_odd;
`ifdef UART_TX_PARITY_EN
    hand_41_even = 11'h482;
`else
    hand_41_even = 11'h682;
`endif
    hand_41_odd = 11'h682;

    // reset and idle
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      check("idle_outputs", 64'({load, shift, tx_done, tx_busy, frame}), 64'({4'b0000, 11'h7FF}));
    end

    // single frame 0x41 even
    send_frame(8'h41, 1'b0, l);
    wait_cyc(l);
    check("frame_41_even", 64'(frame), 64'(hand_41_even));
    check("busy_at_load", 64'(tx_busy), 64'd1);
    wait_cyc(l + 44);
    check("busy_at_done", 64'(tx_busy), 64'd1);
    wait_cyc(l + 45);
    check("busy_after_done", 64'(tx_busy), 64'd0);
    wait_cyc(l + 50);

    // 0x41 odd
    send_frame(8'h41, 1'b1, l);
    wait_cyc(l);
    check("frame_41_odd", 64'(frame), 64'(hand_41_odd));
    wait_cyc(l + 50);
    check("frame_hold_idle", 64'(frame), 64'(hand_41_odd));

    // back-to-back: tx_start held for three frames, data changed mid-frame
    tx_data = 8'h5A; parity_odd = 1'b0; tx_start = 1'b1;
    l0 = cyc + 1; l1 = l0 + 45; l2 = l1 + 45;
    push_frame(l0, exp_frame(8'h5A, 1'b0));
    push_frame(l1, exp_frame(8'hC3, 1'b1));
    push_frame(l2, exp_frame(8'h0F, 1'b0));
    wait_cyc(l0 + 20);
    tx_data = 8'hC3; parity_odd = 1'b1;
    wait_cyc(l1 + 20);
    tx_data = 8'h0F; parity_odd = 1'b0;
    wait_cyc(l2 + 20);
    tx_data = 8'hFF; tx_start = 1'b0;
    wait_cyc(l1 - 1);
    check("b2b_busy_gap", 64'(tx_busy), 64'd1);
    wait_cyc(l2 + 45);
    check("b2b_busy_end", 64'(tx_busy), 64'd0);
    wait_cyc(l2 + 50);

    // ignored tx_start mid-frame
    send_frame(8'h96, 1'b1, l);
    wait_cyc(l + 10);
    tx_data = 8'h00; tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    wait_cyc(l + 45);
    check("ignore_busy_end", 64'(tx_busy), 64'd0);
    check("ignore_frame", 64'(frame), 64'(exp_frame(8'h96, 1'b1)));
    wait_cyc(l + 50);

    // reset mid-frame aborts it
    send_frame(8'hA5, 1'b0, l);
    wait_cyc(l + 20);
    #2;
    rst = 1'b1;
    exp_q.delete();
    #1;
    check("rst_outputs", 64'({load, shift, tx_done, tx_busy, frame}), 64'({4'b0000, 11'h7FF}));
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (60) @(negedge clk);
    check("rst_no_done", 64'(tx_busy), 64'd0);
    send_frame(8'h3C, 1'b0, l);
    wait_cyc(l + 44);
    check("post_rst_busy", 64'(tx_busy), 64'd1);
    wait_cyc(l + 45);
    check("post_rst_idle", 64'(tx_busy), 64'd0);
    wait_cyc(l + 50);

    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_ctrl.md
UART_TX_CTRL -- requirements
Module: uart_tx_ctrl

Interface
REQ-001 The block SHALL have parameter BAUD_DIV, default 5208, giving clk cycles per bit (50 MHz / 9600); legal range 2..65535.
REQ-002 The block SHALL have parameter FRAME_BITS, default 11, giving bits per frame: start, 8 data, parity/stop2, stop.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL be on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port tx_data, input, 8 bits: the byte to send, sampled only on an accepted tx_start.
REQ-006 The block SHALL have port tx_start, input, 1 bit: the send request, level-sampled.
REQ-007 The block SHALL have port parity_odd, input, 1 bit: 1 selects odd parity and 0 selects even parity, sampled with tx_data.
REQ-008 The block SHALL have port frame, output, 11 bits: the parallel frame that feeds the downstream shift register data_in.
REQ-009 The block SHALL have port load, output, 1 bit: a one-cycle pulse that loads frame into the shift register.
REQ-010 The block SHALL have port shift, output, 1 bit: a one-cycle pulse that advances the shift register by one bit.
REQ-011 The block SHALL have port tx_busy, output, 1 bit: high while a frame is in progress.
REQ-012 The block SHALL have port tx_done, output, 1 bit: a one-cycle pulse on the last cycle of the frame.

Function
REQ-013 The frame SHALL be laid out as frame[0]=0 (start), frame[8:1]=tx_data (LSB first on the line), frame[9]=parity bit, frame[10]=1 (stop).
REQ-014 The block SHALL have three states: IDLE, LOAD, SEND.
REQ-015 In IDLE with tx_start=1 at cycle N, the block SHALL latch tx_data and parity_odd, register frame, and enter LOAD; load SHALL be 1 in cycle L=N+1 with frame already valid in that cycle.
REQ-016 The LOAD state SHALL last exactly one cycle, then move to SEND and clear the baud counter and the bit counter.
REQ-017 In SEND, bit period k (k=0..10) SHALL span cycles L+1+k*BAUD_DIV through L+(k+1)*BAUD_DIV.
REQ-018 shift SHALL be 1 on the last cycle of bit periods 0..9 only, giving exactly 10 shift pulses per frame.
REQ-019 On the last cycle of period 10 (cycle L+11*BAUD_DIV), tx_done SHALL be 1 and the block SHALL return to IDLE.
REQ-020 tx_busy SHALL be 1 from cycle L through cycle L+11*BAUD_DIV inclusive, and 0 otherwise.
REQ-021 tx_start asserted while tx_busy=1 SHALL be ignored and not queued; a tx_start held high SHALL start the next frame in the cycle after tx_done (back-to-back operation).
REQ-022 load, shift and tx_done SHALL be mutually exclusive in every cycle.
REQ-023 frame SHALL hold its value from cycle L until the next accepted tx_start.
REQ-024 The baud counter SHALL be 16 bits wide and SHALL wrap to 0 at BAUD_DIV-1; the bit counter SHALL be 4 bits wide and SHALL never exceed 10.

Reset
REQ-025 Asserting rst SHALL immediately force: state=IDLE, both counters=0, frame=11'h7FF, load=0, shift=0, tx_busy=0, tx_done=0.
REQ-026 A reset during SEND SHALL abort the frame with no tx_done pulse; the first tx_start after rst is released SHALL start a fresh frame per REQ-015.

Configuration
REQ-027 With macro UART_TX_PARITY_EN defined, frame[9] SHALL equal the XOR of tx_data[7:0] XORed with parity_odd.
REQ-028 Without UART_TX_PARITY_EN defined, frame[9] SHALL be 1 (second stop bit), parity_odd SHALL be ignored, and the timing SHALL be unchanged.

Structure
REQ-029 Shared package uart_pkg SHALL hold FRAME_BITS, DATA_BITS=8, the state-encoding typedef (IDLE/LOAD/SEND), and the frame bit-index constants.
REQ-030 The baud counter SHALL be a sub-module baud_tick (parameter BAUD_DIV; ports clk, rst, clr, tick) that produces a one-cycle tick at terminal count.

Verification (BAUD_DIV=4 throughout)
REQ-031 rst held then released, no tx_start -> all outputs 0, frame=11'h7FF, tx_busy=0 for 100 cycles.
REQ-032 tx_data=8'h41, one-cycle tx_start -> load at L with frame=11'b1_0_01000001_0 (parity enabled, even, two ones), shift at L+4, L+8, ..., L+40 (10 pulses), tx_done at L+44, tx_busy 0 at L+45.
REQ-033 tx_data=8'h41 with parity_odd=1 -> frame[9]=1; same case compiled without UART_TX_PARITY_EN -> frame[9]=1 for both parity_odd values.
REQ-034 tx_start held high for 3 frames, with tx_data changing only mid-frame -> each frame carries the value latched at its own start, and the next load falls in the cycle after each tx_done.
REQ-035 tx_start pulsed at L+10 during a frame -> ignored; the pulse count, frame, and tx_done timing are unchanged.
REQ-036 rst asserted at L+20 -> load/shift/tx_busy go 0 at once and no tx_done appears; tx_start after rst is released -> a full 44-cycle frame.
